spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 4, number of requesters; N, 1, slave-select width; C, 32, transfer width in bits; QUIET, 8192, post-reset quiet cycles before first grant; TIMEOUT, 65535, watchdog limit in cycles.
REQ-002 CLK_IN  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 req  input  NREQ  per-requester transfer request, level, held until done.
REQ-005 wdata  input  NREQ*C  per-requester write word, requester i at bits [i*C +: C].
REQ-006 target  input  NREQ*N  per-requester slave-select pattern, requester i at [i*N +: N].
REQ-007 grant  output  NREQ  one-hot: requester currently owning the SPI master.
REQ-008 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 rdata  output  C  last captured read word, shared by all requesters.
REQ-010 err  output  1  one-cycle pulse with done when a transfer timed out.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 spi_din  output  C  word to the SPI master.
REQ-013 spi_target  output  N  slave select to the SPI master.
REQ-014 spi_trigger  output  1  start strobe to the SPI master.
REQ-015 spi_dout  input  C  read word from the SPI master.
REQ-016 spi_valid  input  1  SPI master valid: low while a transfer runs, high when finished.

Function
REQ-017 The states SHALL be QUIET, IDLE, TRIG, WAIT_LOW, WAIT_HIGH, DONE.
REQ-018 QUIET: count QUIET cycles, then go to IDLE; grant stays 0 regardless of req.
REQ-019 IDLE: with any req bit set, select the first set bit at or after index (last+1) mod NREQ; latch its wdata/target into spi_din/spi_target; assert its grant bit; go to TRIG.
REQ-020 TRIG: spi_trigger high for exactly one cycle; go to WAIT_LOW.
REQ-021 WAIT_LOW: stay until spi_valid==0, then go to WAIT_HIGH.
REQ-022 WAIT_HIGH: stay until spi_valid==1, then capture spi_dout into rdata and go to DONE.
REQ-023 DONE: pulse done[g] for one cycle; drop grant in the same cycle; set last=g; go to IDLE.
REQ-024 Minimum spacing between grants SHALL be one IDLE cycle; a requester holding req receives another grant only after every other pending requester has been served once.
REQ-025 spi_din/spi_target SHALL stay constant from TRIG until the next IDLE selection; wdata/target changes after latching SHALL be ignored.
REQ-026 req deassertion after grant SHALL NOT abort the transfer; done still pulses.
REQ-027 rdata SHALL hold its value until the next capture or reset.

Reset
REQ-028 RST high SHALL immediately force state QUIET, reload the quiet counter, and clear grant, done, err, spi_trigger, spi_din, spi_target and rdata to 0; last resets to NREQ-1, so requester 0 has first priority.
REQ-029 Reset mid-transfer SHALL abandon the transfer without a done pulse; the QUIET period lets any master transfer still in flight finish before the next trigger.

Configuration
REQ-030 With SPI_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_LOW/WAIT_HIGH; on reaching TIMEOUT it SHALL load rdata with 0, enter DONE and pulse err together with done.
REQ-031 Without SPI_ARB_TIMEOUT_EN, err SHALL be constant 0 and WAIT_LOW/WAIT_HIGH SHALL wait indefinitely.

Verification
REQ-032 Reset, req=4'b0001 before QUIET expires -> no grant until cycle QUIET; then grant=0001, one spi_trigger pulse, spi_din=wdata[31:0].
REQ-033 req=4'b1111 held, master model returns 0xA5A5_0000+i -> grants in order 0,1,2,3,0; each done carries rdata=0xA5A5_0000+i.
REQ-034 req[2] dropped one cycle after grant -> transfer completes, done[2] pulses, next grant goes to the next pending index.
REQ-035 RST asserted in WAIT_HIGH -> grant/done/spi_trigger are 0 in the same cycle, and no trigger occurs for QUIET cycles.
REQ-036 SPI_ARB_TIMEOUT_EN, TIMEOUT=100, spi_valid held 0 -> at cycle 100 done[g]=1, err=1, rdata=0, state IDLE.
REQ-037 Without the macro, same stimulus -> busy stays 1, err never pulses.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master among NREQ requesters using round-robin order.
// A post-reset quiet period lets any master transfer still in flight drain
// before the first new trigger is issued.
// Optional feature: define SPI_ARB_TIMEOUT_EN to add a handshake watchdog.
// With the watchdog, a stalled transfer completes with rdata=0 and an err pulse.
// Without it, err is tied low and the wait states block indefinitely.
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int N       = 1,
  parameter int C       = 32,
  parameter int QUIET   = 8192,
  parameter int TIMEOUT = 65535
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*C-1:0] wdata,
  input  logic [NREQ*N-1:0] target,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [C-1:0]      rdata,
  output logic              err,
  output logic              busy,
  output logic [C-1:0]      spi_din,
  output logic [N-1:0]      spi_target,
  output logic              spi_trigger,
  input  logic [C-1:0]      spi_dout,
  input  logic              spi_valid
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int QW = $clog2(QUIET + 1);

  typedef enum logic [2:0] {
    ST_QUIET,
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [QW-1:0]   quietCnt_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   gidx_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic            trig_q;
  logic [C-1:0]    din_q;
  logic [N-1:0]    tgt_q;
  logic [C-1:0]    rdata_q;

  logic [IW-1:0]   selIdx_d;
  logic            selValid_d;
  logic            tmoHit;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  assign tmoHit = (tmo_q == TW'(TIMEOUT - 1));
`else
  assign tmoHit = 1'b0;
`endif

  // Round-robin search: first requesting index at or after the one past the last served.
  always_comb begin
    int j;
    logic [IW-1:0] jIdx;
    selIdx_d   = '0;
    selValid_d = 1'b0;
    j          = 0;
    jIdx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(last_q) + 1 + k;
      if (j >= NREQ) j = j - NREQ;
      jIdx = IW'(j);
      if (!selValid_d && req[jIdx]) begin
        selValid_d = 1'b1;
        selIdx_d   = jIdx;
      end
    end
  end

  // Sequencer: quiet period, selection and latching, SPI handshake, completion pulse.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state_q    <= ST_QUIET;
      quietCnt_q <= '0;
      last_q     <= IW'(NREQ - 1);
      gidx_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      trig_q     <= 1'b0;
      din_q      <= '0;
      tgt_q      <= '0;
      rdata_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      trig_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      if (state_q == ST_WAIT_LOW || state_q == ST_WAIT_HIGH) begin
        tmo_q <= tmo_q + TW'(1);
      end
`endif
      case (state_q)
        ST_QUIET: begin
          if (quietCnt_q == QW'(QUIET - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            quietCnt_q <= quietCnt_q + QW'(1);
          end
        end
        ST_IDLE: begin
          if (selValid_d) begin
            gidx_q            <= selIdx_d;
            grant_q           <= '0;
            grant_q[selIdx_d] <= 1'b1;
            din_q             <= wdata[selIdx_d*C +: C];
            tgt_q             <= target[selIdx_d*N +: N];
            trig_q            <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q             <= '0;
`endif
            state_q           <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          state_q <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!spi_valid) begin
            state_q <= ST_WAIT_HIGH;
          end else if (tmoHit) begin
            rdata_q <= '0;
            done_q  <= grant_q;
            err_q   <= 1'b1;
            grant_q <= '0;
            state_q <= ST_DONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (spi_valid) begin
            rdata_q <= spi_dout;
            done_q  <= grant_q;
            grant_q <= '0;
            state_q <= ST_DONE;
          end else if (tmoHit) begin
            rdata_q <= '0;
            done_q  <= grant_q;
            err_q   <= 1'b1;
            grant_q <= '0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_q  <= gidx_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign spi_din     = din_q;
  assign spi_target  = tgt_q;
  assign spi_trigger = trig_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized and directed bench for spi_arbiter.
// A transaction-level reference model predicts each grant from the round-robin rule.
// The model also predicts the latched write word and the read word returned with each done.
// The SPI master is a behavioural responder with random handshake delays.
// Define SPI_ARB_TIMEOUT_EN on both files to exercise the watchdog path.
module tb_spi_arbiter;

  localparam int NREQ    = 4;
  localparam int N       = 2;
  localparam int C       = 32;
  localparam int QUIET   = 40;
  localparam int TIMEOUT = 100;

  logic              CLK_IN;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*C-1:0] wdata;
  logic [NREQ*N-1:0] target;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [C-1:0]      rdata;
  logic              err;
  logic              busy;
  logic [C-1:0]      spi_din;
  logic [N-1:0]      spi_target;
  logic              spi_trigger;
  logic [C-1:0]      spi_dout;
  logic              spi_valid;

  int totalChecks = 0;
  int badChecks   = 0;

  // Master model controls and the word it last returned.
  logic         forceLow      = 1'b0;
  logic         respRandom    = 1'b0;
  logic         expectTimeout = 1'b0;
  logic [C-1:0] lastResp      = '0;

  int expOrder[5] = '{0, 1, 2, 3, 0};

  spi_arbiter #(
    .NREQ(NREQ), .N(N), .C(C), .QUIET(QUIET), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_IN(CLK_IN), .RST(RST), .req(req), .wdata(wdata), .target(target),
    .grant(grant), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .spi_din(spi_din), .spi_target(spi_target), .spi_trigger(spi_trigger),
    .spi_dout(spi_dout), .spi_valid(spi_valid)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oneHot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    if (idx >= 0 && idx < NREQ) v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first set bit at or after (last+1) mod NREQ.
  function automatic int pickNext(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*C-1:0] randWords();
    logic [NREQ*C-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i*C +: C] = C'($urandom);
    return v;
  endfunction

  // Behavioural SPI master: after a trigger, drop valid, then raise it with a read word.
  initial begin
    int mState;
    int mCount;
    logic [C-1:0] resp;
    mState = 0;
    mCount = 0;
    resp = '0;
    spi_valid = 1'b1;
    spi_dout = '0;
    forever begin
      @(negedge CLK_IN);
      if (forceLow) begin
        spi_valid = 1'b0;
        mState = 0;
      end else begin
        case (mState)
          0: begin
            spi_valid = 1'b1;
            if (spi_trigger && !RST) begin
              if (respRandom) begin
                resp = C'($urandom);
              end else begin
                resp = '0;
                for (int i = 0; i < NREQ; i++) if (grant[i]) resp = 32'hA5A5_0000 + i;
              end
              mCount = $urandom_range(0, 2);
              mState = 1;
            end
          end
          1: begin
            if (mCount == 0) begin
              spi_valid = 1'b0;
              mCount = $urandom_range(1, 4);
              mState = 2;
            end else begin
              mCount--;
            end
          end
          default: begin
            if (mCount == 0) begin
              spi_dout = resp;
              spi_valid = 1'b1;
              lastResp = resp;
              mState = 0;
            end else begin
              mCount--;
            end
          end
        endcase
      end
    end
  end

  // Reference model and scoreboard, evaluated once per cycle away from the clock edge.
  logic [NREQ-1:0]   reqPrev, prevGrant;
  logic [NREQ*C-1:0] wdataPrev;
  logic [NREQ*N-1:0] targetPrev;
  logic [C-1:0]      expDin;
  logic [N-1:0]      expTgt;
  int                mLast, curIdx, trigCnt, expIdx;
  logic              afterDone;

  initial begin
    reqPrev = '0; prevGrant = '0; wdataPrev = '0; targetPrev = '0;
    expDin = '0; expTgt = '0; mLast = NREQ - 1; curIdx = -1; trigCnt = 0;
    expIdx = -1; afterDone = 1'b0;
  end

  always @(negedge CLK_IN) begin
    if (RST) begin
      mLast = NREQ - 1;
      curIdx = -1;
      prevGrant = '0;
      afterDone = 1'b0;
      trigCnt = 0;
    end else begin
      if (afterDone) checkOutput("idleAfterDone", busy, 1'b0);
      afterDone = 1'b0;
      if (grant != '0 && prevGrant == '0) begin
        expIdx = pickNext(reqPrev, mLast);
        checkOutput("grantPick", grant, oneHot(expIdx));
        checkOutput("trigWithGrant", spi_trigger, 1'b1);
        expDin = (expIdx >= 0) ? wdataPrev[expIdx*C +: C] : '0;
        expTgt = (expIdx >= 0) ? targetPrev[expIdx*N +: N] : '0;
        checkOutput("dinLatch", spi_din, expDin);
        checkOutput("tgtLatch", spi_target, expTgt);
        curIdx = expIdx;
        trigCnt = 0;
      end
      if (spi_trigger) trigCnt++;
      if (done != '0) begin
        checkOutput("doneIdx", done, oneHot(curIdx));
        checkOutput("grantDropped", grant, '0);
        checkOutput("doneRdata", rdata, expectTimeout ? '0 : lastResp);
        checkOutput("doneErr", err, expectTimeout);
        checkOutput("dinHeld", spi_din, expDin);
        checkOutput("tgtHeld", spi_target, expTgt);
        checkOutput("trigOnce", trigCnt, 1);
        mLast = curIdx;
        curIdx = -1;
        afterDone = 1'b1;
      end
      prevGrant = grant;
    end
    reqPrev = req;
    wdataPrev = wdata;
    targetPrev = target;
  end

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*C-1:0] w,
                               input logic [NREQ*N-1:0] t);
    @(posedge CLK_IN);
    #2;
    req = r;
    wdata = w;
    target = t;
  endtask

  task automatic doReset(input logic [NREQ-1:0] r);
    @(posedge CLK_IN);
    #2;
    RST = 1'b1;
    req = r;
    repeat (2) @(negedge CLK_IN);
    checkOutput("rstGrant", grant, '0);
    checkOutput("rstDone", done, '0);
    checkOutput("rstTrig", spi_trigger, 1'b0);
    checkOutput("rstRdata", rdata, '0);
    checkOutput("rstDin", spi_din, '0);
    checkOutput("rstTgt", spi_target, '0);
    checkOutput("rstErr", err, 1'b0);
    checkOutput("rstBusy", busy, 1'b1);
    @(posedge CLK_IN);
    #2;
    RST = 1'b0;
  endtask

  // Number of rising edges after reset release until the first grant is visible.
  task automatic countToGrant(output int cycles);
    cycles = 0;
    for (int n = 1; n <= QUIET + 50; n++) begin
      @(posedge CLK_IN);
      @(negedge CLK_IN);
      if (grant != '0) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic waitGrant(input int limit, output logic [NREQ-1:0] g);
    g = '0;
    for (int n = 0; n < limit; n++) begin
      @(negedge CLK_IN);
      if (grant != '0) begin
        g = grant;
        break;
      end
    end
    checkOutput("waitGrant", (g != '0), 1'b1);
  endtask

  task automatic waitDone(input int limit, output logic [NREQ-1:0] d);
    d = '0;
    for (int n = 0; n < limit; n++) begin
      @(negedge CLK_IN);
      if (done != '0) begin
        d = done;
        break;
      end
    end
    checkOutput("waitDone", (d != '0), 1'b1);
  endtask

  initial begin
    int cyc;
    logic [NREQ-1:0] d, g, r;
    logic [NREQ*C-1:0] w;
    logic [NREQ*N-1:0] t;
    logic busyLow, errSeen;

    RST = 1'b1;
    req = '0;
    w = randWords();
    w[C-1:0] = 32'h1234_5678;
    wdata = w;
    t = '0;
    t[N-1:0] = 2'b10;
    target = t;
    busyLow = 1'b0;
    errSeen = 1'b0;

    // Requester 0 asks during reset; no grant until the quiet period ends.
    doReset(4'b0001);
    countToGrant(cyc);
    checkOutput("quietLen", cyc, QUIET + 1);
    checkOutput("firstGrant", grant, 4'b0001);
    checkOutput("firstDin", spi_din, 32'h1234_5678);
    checkOutput("firstTgt", spi_target, 2'b10);
    checkOutput("firstTrig", spi_trigger, 1'b1);
    waitDone(60, d);
    checkOutput("firstDone", d, 4'b0001);
    checkOutput("firstRdata", rdata, 32'hA5A5_0000);
    applyStimulus('0, wdata, target);

    // All four requesters held: rotation 0,1,2,3,0 after a fresh reset.
    doReset(4'b1111);
    countToGrant(cyc);
    checkOutput("quietLen2", cyc, QUIET + 1);
    for (int k = 0; k < 5; k++) begin
      waitDone(60, d);
      checkOutput("rrOrder", d, oneHot(expOrder[k]));
      checkOutput("rrRdata", rdata, 32'hA5A5_0000 + expOrder[k]);
    end
    applyStimulus('0, wdata, target);

    // Requester 2 drops its request right after being granted; transfer still completes.
    applyStimulus(4'b1101, wdata, target);
    waitGrant(20, g);
    checkOutput("dropGrant", g, 4'b0100);
    applyStimulus(4'b1001, wdata, target);
    waitDone(60, d);
    checkOutput("dropDone", d, 4'b0100);
    waitGrant(20, g);
    checkOutput("dropNext", g, 4'b1000);
    waitDone(60, d);
    checkOutput("dropNextDone", d, 4'b1000);
    applyStimulus('0, wdata, target);

    // Random requests and data churn; the scoreboard checks every grant and done.
    respRandom = 1'b1;
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) r = NREQ'($urandom);
      applyStimulus(r, randWords(), (NREQ*N)'($urandom));
    end
    applyStimulus('0, wdata, target);
    repeat (30) @(negedge CLK_IN);

    // Reset while waiting for the master to finish: outputs clear at once, quiet period reruns.
    forceLow = 1'b1;
    applyStimulus(4'b0001, randWords(), target);
    waitGrant(20, g);
    repeat (3) @(negedge CLK_IN);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("midRstGrant", grant, '0);
    checkOutput("midRstDone", done, '0);
    checkOutput("midRstTrig", spi_trigger, 1'b0);
    checkOutput("midRstRdata", rdata, '0);
    checkOutput("midRstBusy", busy, 1'b1);
    @(posedge CLK_IN);
    #2;
    RST = 1'b0;
    forceLow = 1'b0;
    countToGrant(cyc);
    checkOutput("quietLen3", cyc, QUIET + 1);
    checkOutput("midRstRegrant", grant, 4'b0001);
    waitDone(60, d);
    checkOutput("midRstDoneAfter", d, 4'b0001);
    applyStimulus('0, wdata, target);

    // Master never finishes: watchdog fires if present, otherwise the arbiter keeps waiting.
    forceLow = 1'b1;
    applyStimulus(4'b0010, randWords(), target);
    waitGrant(20, g);
    checkOutput("stallGrant", g, 4'b0010);
`ifdef SPI_ARB_TIMEOUT_EN
    expectTimeout = 1'b1;
    waitDone(TIMEOUT + 20, d);
    checkOutput("tmoDone", d, 4'b0010);
    checkOutput("tmoErr", err, 1'b1);
    checkOutput("tmoRdata", rdata, '0);
    forceLow = 1'b0;
    applyStimulus('0, wdata, target);
    expectTimeout = 1'b0;
    @(negedge CLK_IN);
    checkOutput("tmoIdle", busy, 1'b0);
`else
    repeat (TIMEOUT + 20) begin
      @(negedge CLK_IN);
      if (!busy) busyLow = 1'b1;
      if (err) errSeen = 1'b1;
    end
    checkOutput("noTmoBusy", busyLow, 1'b0);
    checkOutput("noTmoErr", errSeen, 1'b0);
    forceLow = 1'b0;
    waitDone(60, d);
    checkOutput("stallRelease", d, 4'b0010);
    applyStimulus('0, wdata, target);
`endif
    repeat (5) @(negedge CLK_IN);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
